// File: rtl/ifid_stage_buffer_if.sv
// ifid_stage_buffer_if: fetch/decode handshake bundle for the IF/ID stage buffer
interface ifid_stage_buffer_if #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W = 16
);
  logic flush_i;
  logic in_valid_i;
  logic in_ready_o;
  logic [PC_W-1:0] pc_i;
  logic [INSTR_W-1:0] instr_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [PC_W-1:0] pc_o;
  logic [INSTR_W-1:0] instr_o;
  logic [CNT_W-1:0] stall_cnt_o;
  modport master (
    output flush_i, in_valid_i, pc_i, instr_i, out_ready_i,
    input in_ready_o, out_valid_o, pc_o, instr_o, stall_cnt_o
  );
  modport slave (
    input flush_i, in_valid_i, pc_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, instr_o, stall_cnt_o
  );
endinterface

// File: rtl/ifid_stage_buffer.sv
// ifid_stage_buffer: IF/ID register with skid buffer, flush bubbles and stall counter
module ifid_stage_buffer #(
  parameter int PC_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  ifid_stage_buffer_if.slave bus
);
  // state encoding is {out_valid, skid_valid}
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc_q, pc_n, skid_pc, skid_pc_n;
  logic [INSTR_W-1:0] instr_q, instr_n, skid_instr, skid_instr_n;
  logic [CNT_W-1:0] cnt;
  logic accept, fire;
  assign bus.in_ready_o = state != FULL;
  assign bus.out_valid_o = state != EMPTY;
  assign bus.pc_o = pc_q;
  assign bus.instr_o = instr_q;
  assign bus.stall_cnt_o = cnt;
  assign accept = bus.in_valid_i & (state != FULL);
  assign fire = (state != EMPTY) & bus.out_ready_i;
  always_comb begin
    state_n = state;
    pc_n = pc_q;
    instr_n = instr_q;
    skid_pc_n = skid_pc;
    skid_instr_n = skid_instr;
    case (state)
      EMPTY: if (accept) begin
        state_n = ONE;
        pc_n = bus.pc_i;
        instr_n = bus.instr_i;
      end
      ONE: if (accept && fire) begin
        pc_n = bus.pc_i;
        instr_n = bus.instr_i;
      end else if (accept) begin
        state_n = FULL;
        skid_pc_n = bus.pc_i;
        skid_instr_n = bus.instr_i;
      end else if (fire) state_n = EMPTY;
      FULL: if (fire) begin
        state_n = ONE;
        pc_n = skid_pc;
        instr_n = skid_instr;
      end
      default: state_n = EMPTY;
    endcase
    if (bus.flush_i) state_n = EMPTY;
    // an empty output register always presents a bubble
    if (state_n == EMPTY) begin
      pc_n = '0;
      instr_n = NOP_INSTR;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      pc_q <= '0;
      instr_q <= NOP_INSTR;
      cnt <= '0;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
      instr_q <= instr_n;
      if (bus.out_valid_o && !bus.out_ready_i && !(&cnt)) cnt <= cnt + 1'b1;
    end
    skid_pc <= skid_pc_n;
    skid_instr <= skid_instr_n;
  end
endmodule

// File: tb/tb_ifid_stage_buffer.sv
// tb_ifid_stage_buffer: directed stimulus with a scoreboard of expected decode beats
module tb_ifid_stage_buffer;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  ifid_stage_buffer_if #(.PC_W(32), .INSTR_W(32), .CNT_W(4)) bus ();
  ifid_stage_buffer #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .CNT_W(4)) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [31:0] p);
    return p ^ 32'hCAFE_0000;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] p, input logic r, input logic f);
    bus.in_valid_i = v;
    bus.pc_i = p;
    bus.instr_i = ins(p);
    bus.out_ready_i = r;
    bus.flush_i = f;
  endtask
  task automatic push(input logic [31:0] p);
    exp_q.push_back({p, ins(p)});
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!reset && bus.out_valid_o && bus.out_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat: unexpected pc %h instr %h, expected none", bus.pc_o, bus.instr_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.pc_o, bus.instr_o} !== e) begin
          n_err++;
          $display("FAIL beat: got pc %h instr %h expected pc %h instr %h",
                   bus.pc_o, bus.instr_o, e[63:32], e[31:0]);
        end
      end
    end
  end
  initial begin
    reset = 1'b1;
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    step;
    step;
    chk("rst_out_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    chk("rst_instr", bus.instr_o, NOP);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_cnt", {28'b0, bus.stall_cnt_o}, 32'd0);
    reset = 1'b0;
    // streaming
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
      push(32'(i * 4));
      step;
      chk("stream_valid", {31'b0, bus.out_valid_o}, 32'd1);
      chk("stream_pc", bus.pc_o, 32'(i * 4));
      chk("stream_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step;
    chk("drain_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("drain_pc", bus.pc_o, 32'h0);
    chk("drain_instr", bus.instr_o, NOP);
    // skid fill and drain
    drive(1'b1, 32'h10, 1'b1, 1'b0);
    push(32'h10);
    step;
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    push(32'h14);
    step;
    chk("skid_in_ready", {31'b0, bus.in_ready_o}, 32'd0);
    chk("skid_pc_hold", bus.pc_o, 32'h10);
    drive(1'b1, 32'h18, 1'b0, 1'b0);
    step;
    chk("full_in_ready", {31'b0, bus.in_ready_o}, 32'd0);
    chk("full_pc_hold", bus.pc_o, 32'h10);
    chk("full_instr_hold", bus.instr_o, ins(32'h10));
    drive(1'b1, 32'h18, 1'b1, 1'b0);
    step;
    chk("unskid_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    chk("unskid_pc", bus.pc_o, 32'h14);
    push(32'h18);
    step;
    chk("after_skid_pc", bus.pc_o, 32'h18);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step;
    chk("skid_cnt", {28'b0, bus.stall_cnt_o}, 32'd2);
    // flush while full with an attempted accept
    drive(1'b1, 32'h20, 1'b1, 1'b0);
    step;
    drive(1'b1, 32'h24, 1'b0, 1'b0);
    step;
    chk("pre_flush_full", {31'b0, bus.in_ready_o}, 32'd0);
    drive(1'b1, 32'h28, 1'b0, 1'b1);
    step;
    chk("flush_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("flush_instr", bus.instr_o, NOP);
    chk("flush_pc", bus.pc_o, 32'h0);
    chk("flush_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    chk("flush_cnt", {28'b0, bus.stall_cnt_o}, 32'd4);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step;
    step;
    // flush in ONE: the firing beat is consumed, the accepted beat dropped
    drive(1'b1, 32'h30, 1'b1, 1'b0);
    push(32'h30);
    step;
    drive(1'b1, 32'h34, 1'b1, 1'b1);
    step;
    chk("flush1_valid", {31'b0, bus.out_valid_o}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step;
    chk("flush1_stays_empty", {31'b0, bus.out_valid_o}, 32'd0);
    // reset together with flush while full
    reset = 1'b1;
    step;
    reset = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    step;
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    step;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) step;
    chk("pre_rst_cnt", {28'b0, bus.stall_cnt_o}, 32'd5);
    chk("pre_rst_full", {31'b0, bus.in_ready_o}, 32'd0);
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    step;
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("rstflush_cnt", {28'b0, bus.stall_cnt_o}, 32'd0);
    chk("rstflush_valid", {31'b0, bus.out_valid_o}, 32'd0);
    chk("rstflush_in_ready", {31'b0, bus.in_ready_o}, 32'd1);
    // counter saturation
    drive(1'b1, 32'h50, 1'b1, 1'b0);
    push(32'h50);
    step;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (20) step;
    chk("sat_cnt", {28'b0, bus.stall_cnt_o}, 32'd15);
    chk("sat_pc_hold", bus.pc_o, 32'h50);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step;
    chk("sat_cnt_after", {28'b0, bus.stall_cnt_o}, 32'd15);
    chk("sat_drained", {31'b0, bus.out_valid_o}, 32'd0);
    step;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
